serial_subtractor: RTL and testbench

Parametrised bit-serial subtractor computing `a - b - borrow_in` over `WIDTH` bits, one bit per clock, LSB first, with a start/busy/done handshake. It is the sequential successor to the combinational half subtractor. It trades area for latency by reusing a single full-subtractor cell and a borrow flop across all bit positions. It also adds borrow-in chaining and a signed-overflow flag. It sits behind any controller that can wait `WIDTH` cycles for a result.

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 93 +++++++++
 tb/tb_serial_subtractor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`timescale 1ns/1ps
// Operand/result bundle for the bit-serial subtractor.
// The master side launches operations and the slave side returns held results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, borrow_in,
        input  diff, borrow_out, overflow, busy, done
    );

    modport slave (
        input  start, a, b, borrow_in,
        output diff, borrow_out, overflow, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// Bit-serial a - b - borrow_in, LSB first; done pulses WIDTH edges after the accepting edge.
// No backpressure: start is ignored while busy, and results hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
    logic [CW-1:0]    cnt;
    logic             br, d_bit, br_nxt, last, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sif.busy  = 1'b0;
        sif.done  = 1'b0;
        case (state)
            IDLE: begin
                if (sif.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                sif.busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                sif.done = 1'b1;
                if (sif.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One full-subtractor cell; the result enters at the MSB so bit 0 lands at index 0 after WIDTH shifts.
    always_comb begin
        d_bit            = a_sr[0] ^ b_sr[0] ^ br;
        br_nxt           = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_nxt          = res_sr >> 1;
        res_nxt[WIDTH-1] = d_bit;
        last             = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr           <= '0;
            b_sr           <= '0;
            res_sr         <= '0;
            br             <= 1'b0;
            cnt            <= '0;
            sif.diff       <= '0;
            sif.borrow_out <= 1'b0;
            sif.overflow   <= 1'b0;
        end else if (accept) begin
            a_sr   <= sif.a;
            b_sr   <= sif.b;
            br     <= sif.borrow_in;
            res_sr <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            br     <= br_nxt;
            cnt    <= cnt + CW'(1);
            // br is the borrow into the MSB while the last bit is processed.
            if (last) begin
                sif.diff       <= res_nxt;
                sif.borrow_out <= br_nxt;
                sif.overflow   <= br ^ br_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes hand-computed results, monitors pop on done.
module tb_serial_subtractor;
    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_subtractor_if #(.WIDTH(8)) sif8 ();
    serial_subtractor_if #(.WIDTH(1)) sif1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .sif(sif8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .sif(sif1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sif8.done === 1'b1) begin
            chk("w8_done_expected", 32'(q8.size() > 0), 32'd1);
            chk("w8_busy_with_done", 32'(sif8.busy), 32'd0);
            if (q8.size() > 0) begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_diff", 32'(sif8.diff), 32'(e.d));
                chk("w8_borrow_out", 32'(sif8.borrow_out), 32'(e.bo));
                chk("w8_overflow", 32'(sif8.overflow), 32'(e.ov));
                chk("w8_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (sif1.done === 1'b1) begin
            chk("w1_done_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("w1_diff", 32'(sif1.diff), 32'(e.d[0]));
                chk("w1_borrow_out", 32'(sif1.borrow_out), 32'(e.bo));
                chk("w1_overflow", 32'(sif1.overflow), 32'(e.ov));
                chk("w1_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] d, input logic bo, input logic ov);
        @(negedge clk);
        sif8.start = 1'b1; sif8.a = a; sif8.b = b; sif8.borrow_in = bi;
        q8.push_back('{d: d, bo: bo, ov: ov, due: cyc + 9});
        @(negedge clk);
        sif8.start = 1'b0; sif8.a = 8'hAA; sif8.b = 8'h55; sif8.borrow_in = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic op1(input logic a, input logic b, input logic bi, input logic [2:0] r);
        @(negedge clk);
        sif1.start = 1'b1; sif1.a = a; sif1.b = b; sif1.borrow_in = bi;
        q1.push_back('{d: {7'd0, r[2]}, bo: r[1], ov: r[0], due: cyc + 2});
        @(negedge clk);
        sif1.start = 1'b0; sif1.a = ~a; sif1.b = ~b; sif1.borrow_in = ~bi;
        repeat (3) @(negedge clk);
    endtask

    // {diff, borrow_out, overflow} for {a, b, borrow_in} = 0..7
    logic [2:0] w1_tab [8] = '{3'b000, 3'b110, 3'b111, 3'b010,
                               3'b100, 3'b001, 3'b000, 3'b110};

    initial begin
        int c;
        sif8.start = 1'b0; sif8.a = '0; sif8.b = '0; sif8.borrow_in = 1'b0;
        sif1.start = 1'b0; sif1.a = '0; sif1.b = '0; sif1.borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_diff", 32'(sif8.diff), 32'd0);
        chk("rst_borrow_out", 32'(sif8.borrow_out), 32'd0);
        chk("rst_overflow", 32'(sif8.overflow), 32'd0);
        chk("rst_busy", 32'(sif8.busy), 32'd0);
        chk("rst_done", 32'(sif8.done), 32'd0);
        chk("rst_w1_diff", 32'(sif1.diff), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Handshake: re-pulse while busy is ignored; start held through DONE chains a second op.
        @(negedge clk);
        c = cyc;
        sif8.start = 1'b1; sif8.a = 8'h05; sif8.b = 8'h03; sif8.borrow_in = 1'b0;
        q8.push_back('{d: 8'h02, bo: 1'b0, ov: 1'b0, due: c + 9});
        wait_to(c + 1);
        sif8.start = 1'b0;
        wait_to(c + 3);
        sif8.start = 1'b1; sif8.a = 8'h10; sif8.b = 8'h01;
        wait_to(c + 4);
        sif8.start = 1'b0;
        wait_to(c + 8);
        sif8.start = 1'b1;
        q8.push_back('{d: 8'h0F, bo: 1'b0, ov: 1'b0, due: c + 18});
        wait_to(c + 10);
        sif8.start = 1'b0; sif8.a = 8'hAA;
        wait_to(c + 21);
        chk("busy_idle_after_chain", 32'(sif8.busy), 32'd0);

        // Reset three edges into RUN: outputs clear asynchronously and no done follows.
        @(negedge clk);
        c = cyc;
        sif8.start = 1'b1; sif8.a = 8'h7F; sif8.b = 8'h01; sif8.borrow_in = 1'b0;
        wait_to(c + 1);
        sif8.start = 1'b0;
        wait_to(c + 4);
        chk("busy_mid_run", 32'(sif8.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_diff", 32'(sif8.diff), 32'd0);
        chk("midrst_borrow_out", 32'(sif8.borrow_out), 32'd0);
        chk("midrst_overflow", 32'(sif8.overflow), 32'd0);
        chk("midrst_busy", 32'(sif8.busy), 32'd0);
        chk("midrst_done", 32'(sif8.done), 32'd0);
        wait_to(c + 5);
        rst = 1'b0;
        wait_to(c + 17);
        op8(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0], w1_tab[i]);
        end

        repeat (4) @(negedge clk);
        chk("w8_pending_results", 32'(q8.size()), 32'd0);
        chk("w1_pending_results", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
